// File: rtl/free_list_if.sv
// -----------------------------------------------------------------------------
// free_list_if
//   Bundles the rename/retire-facing signals of the physical-register free
//   list.
//
//   Handshake: the allocator offers alloc_phys with alloc_valid. A grant
//   happens on a rising clk edge where alloc_req && alloc_valid. alloc_valid
//   never depends on alloc_req. retire_en is a one-cycle push with no
//   back-pressure. flush is a one-cycle recovery strobe.
//
//   Modports:
//     master - renamer/ROB side: drives flush, alloc_req, retire_en,
//              retire_old_phys.
//     slave  - free list side: drives alloc_valid, alloc_phys, free_count,
//              empty, err.
// -----------------------------------------------------------------------------
interface free_list_if #(
  parameter int PHYS_REG_BITS = 6
);
  logic                     flush;
  logic                     alloc_req;
  logic                     alloc_valid;
  logic [PHYS_REG_BITS-1:0] alloc_phys;
  logic                     retire_en;
  logic [PHYS_REG_BITS-1:0] retire_old_phys;
  logic [PHYS_REG_BITS:0]   free_count;
  logic                     empty;
  logic                     err;

  modport master (
    output flush, alloc_req, retire_en, retire_old_phys,
    input  alloc_valid, alloc_phys, free_count, empty, err
  );

  modport slave (
    input  flush, alloc_req, retire_en, retire_old_phys,
    output alloc_valid, alloc_phys, free_count, empty, err
  );
endinterface

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Physical-register free list and allocator for the rename stage.
//   It is a circular buffer of free register indices with three pointers:
//     hd  - speculative head. Rename allocates from here.
//     chd - committed head. It advances once per retire.
//     tl  - tail. Retired old mappings are appended here.
//   Each pointer has one extra wrap bit. A flush snaps hd back to chd, which
//   returns every speculatively allocated register in one cycle.
//
//   Optional build macro FREELIST_CHECK_EN adds a per-register is_free
//   vector. It flags double frees, frees of phys 0, and grants of registers
//   that are not free. After a flush the vector is rebuilt by a walk from chd
//   to tl. Allocation is held off while the walk runs. The walk FSM state is
//   visible on dbg_walk.
//
//   Ports:
//     clk, rst  - clock; asynchronous active-high reset.
//     bus       - free_list_if.slave (flush, alloc_*, retire_*, free_count,
//                 empty, err).
//     dbg_walk  - (FREELIST_CHECK_EN only) high while the restore walk runs.
// -----------------------------------------------------------------------------
module free_list #(
  parameter int PHYS_REG_BITS = 6,
  parameter int NUM_ARCH      = 32
) (
  input  logic        clk,
  input  logic        rst,
  free_list_if.slave  bus
`ifdef FREELIST_CHECK_EN
  ,
  output logic        dbg_walk
`endif
);

  localparam int NUM_PHYS = 1 << PHYS_REG_BITS;
  localparam int NUM_FREE = NUM_PHYS - NUM_ARCH;

  typedef logic [PHYS_REG_BITS:0]   ptr_t;
  typedef logic [PHYS_REG_BITS-1:0] phys_t;

  phys_t entries [NUM_PHYS];
  ptr_t  hd, chd, tl;
  ptr_t  hd_nxt, chd_nxt;
  ptr_t  count;
  logic  overflow;
  logic  retire_ok;
  logic  alloc_ok;
  logic  grant;
  logic  err_set;
  logic  err_q;

  // The count uses modulo 2*NUM_PHYS subtraction. The wrap bit makes a full
  // list (NUM_PHYS) distinct from an empty one (0).
  assign count     = tl - hd;
  assign overflow  = bus.retire_en && (count == ptr_t'(NUM_PHYS));
  assign retire_ok = bus.retire_en && !overflow;

  // alloc_valid uses the count before any retire in this cycle. A register
  // freed now cannot be granted before the next cycle.
  assign bus.alloc_valid = (count != '0) && !bus.flush && alloc_ok;
  assign bus.alloc_phys  = entries[hd[PHYS_REG_BITS-1:0]];
  assign bus.free_count  = count;
  assign bus.empty       = (count == '0);
  assign bus.err         = err_q;

  assign grant   = bus.alloc_req && bus.alloc_valid;
  assign chd_nxt = chd + ptr_t'(retire_ok);

  // A retire in the flush cycle belongs to an older instruction and still
  // commits. The restored head is therefore the updated chd.
  always_comb begin
    hd_nxt = hd;
    if (bus.flush) begin
      hd_nxt = chd_nxt;
    end else if (grant) begin
      hd_nxt = hd + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd  <= '0;
      chd <= '0;
      tl  <= ptr_t'(NUM_FREE);
    end else begin
      hd  <= hd_nxt;
      chd <= chd_nxt;
      if (retire_ok) begin
        tl <= tl + 1'b1;
      end
    end
  end

  // Phys NUM_ARCH..NUM_PHYS-1 start free. Phys 0..NUM_ARCH-1 hold the
  // reset architectural mapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        entries[i] <= (i < NUM_FREE) ? phys_t'(NUM_ARCH + i) : '0;
      end
    end else if (retire_ok) begin
      entries[tl[PHYS_REG_BITS-1:0]] <= bus.retire_old_phys;
    end
  end

`ifdef FREELIST_CHECK_EN
  typedef enum logic {
    WALK_IDLE = 1'b0,
    WALK_RUN  = 1'b1
  } walk_state_t;

  walk_state_t         state, state_nxt;
  ptr_t                wp;
  logic [NUM_PHYS-1:0] is_free;

  assign alloc_ok = (state == WALK_IDLE);
  assign dbg_walk = (state == WALK_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WALK_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The walk ends when wp reaches the live tail. A retire that lands while
  // the walk runs sets its own bit, so the moving tail needs no special case.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = WALK_RUN;
    end else if ((state == WALK_RUN) && (wp == tl)) begin
      state_nxt = WALK_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      is_free <= {{NUM_FREE{1'b1}}, {NUM_ARCH{1'b0}}};
    end else begin
      if (bus.flush) begin
        // Start from an empty vector and let the walk refill it.
        is_free <= '0;
        wp      <= chd_nxt;
      end else if ((state == WALK_RUN) && (wp != tl)) begin
        is_free[entries[wp[PHYS_REG_BITS-1:0]]] <= 1'b1;
        wp <= wp + 1'b1;
      end
      if (grant) begin
        is_free[bus.alloc_phys] <= 1'b0;
      end
      if (retire_ok) begin
        is_free[bus.retire_old_phys] <= 1'b1;
      end
    end
  end

  always_comb begin
    err_set = overflow;
    if (bus.retire_en && (bus.retire_old_phys == '0)) begin
      err_set = 1'b1;
    end
    if (bus.retire_en && is_free[bus.retire_old_phys]) begin
      err_set = 1'b1;
    end
    if (grant && !is_free[bus.alloc_phys]) begin
      err_set = 1'b1;
    end
  end
`else
  assign alloc_ok = 1'b1;

  always_comb begin
    err_set = overflow;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
//   Directed bench for free_list. Inputs change 1 time unit after the rising
//   edge. Outputs are sampled at least 1 unit later, well before the next
//   edge.
// -----------------------------------------------------------------------------
module tb_free_list;
  localparam int PRB = 6;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  free_list_if #(.PHYS_REG_BITS(PRB)) bus ();
`ifdef FREELIST_CHECK_EN
  logic dbg_walk;
`endif

  free_list #(.PHYS_REG_BITS(PRB), .NUM_ARCH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FREELIST_CHECK_EN
    ,
    .dbg_walk (dbg_walk)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush           = 1'b0;
    bus.alloc_req       = 1'b0;
    bus.retire_en       = 1'b0;
    bus.retire_old_phys = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_alloc_valid(input string name);
    int n = 0;
    while (bus.alloc_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (bus.alloc_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait: alloc_valid=%0b after %0d cycles, want 1", name, bus.alloc_valid, n);
    end
  endtask

  // Pops n registers and compares each one with base+i. The last one is
  // compared with last_val instead when use_last is set.
  task automatic drain(input string name, input int n, input int base,
                       input bit use_last, input int last_val);
    int exp;
    for (int i = 0; i < n; i++) begin
      bus.alloc_req = 1'b1;
      #1;
      exp = (use_last && i == n - 1) ? last_val : base + i;
      checks++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_phys !== PRB'(exp)) begin
        errors++;
        $display("FAIL %s[%0d]: valid=%0b phys=%0d, want valid=1 phys=%0d",
                 name, i, bus.alloc_valid, bus.alloc_phys, exp);
      end
      step();
    end
    bus.alloc_req = 1'b0;
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.free_count !== 7'd32 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL reset_count: count=%0d empty=%0b, want 32/0", bus.free_count, bus.empty);
    end
    checks++;
    if (bus.alloc_valid !== 1'b1 || bus.alloc_phys !== 6'd32) begin
      errors++;
      $display("FAIL reset_alloc: valid=%0b phys=%0d, want 1/32", bus.alloc_valid, bus.alloc_phys);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%0b, want 0", bus.err);
    end
  endtask

  task automatic test_alloc_all();
    drain("alloc_all", 32, 32, 1'b0, 0);
    bus.alloc_req = 1'b1;
    #1;
    checks++;
    if (bus.empty !== 1'b1 || bus.alloc_valid !== 1'b0 || bus.free_count !== 7'd0) begin
      errors++;
      $display("FAIL empty_state: empty=%0b valid=%0b count=%0d, want 1/0/0",
               bus.empty, bus.alloc_valid, bus.free_count);
    end
    step();
    checks++;
    if (bus.free_count !== 7'd0) begin
      errors++;
      $display("FAIL empty_hold: count=%0d, want 0", bus.free_count);
    end
    bus.alloc_req = 1'b0;
  endtask

  task automatic test_retire_from_empty();
    bus.alloc_req       = 1'b1;
    bus.retire_en       = 1'b1;
    bus.retire_old_phys = 6'd5;
    #1;
    checks++;
    if (bus.alloc_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: valid=%0b, want 0", bus.alloc_valid);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (bus.free_count !== 7'd1 || bus.alloc_phys !== 6'd5 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL retire_empty: count=%0d phys=%0d empty=%0b, want 1/5/0",
               bus.free_count, bus.alloc_phys, bus.empty);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drain("flush_pre", 3, 32, 1'b0, 0);
    bus.retire_en       = 1'b1;
    bus.retire_old_phys = 6'd7;
    step();
    idle_inputs();
    bus.flush     = 1'b1;
    bus.alloc_req = 1'b1;
    #1;
    checks++;
    if (bus.alloc_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: valid=%0b, want 0", bus.alloc_valid);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (bus.free_count !== 7'd32) begin
      errors++;
      $display("FAIL flush_count: count=%0d, want 32", bus.free_count);
    end
    wait_alloc_valid("flush");
    checks++;
    if (bus.alloc_phys !== 6'd33) begin
      errors++;
      $display("FAIL flush_head: phys=%0d, want 33", bus.alloc_phys);
    end
    drain("flush_list", 32, 33, 1'b1, 7);
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_drained: empty=%0b, want 1", bus.empty);
    end
  endtask

  task automatic test_flush_retire();
    do_reset();
    drain("fr_pre", 2, 32, 1'b0, 0);
    bus.flush           = 1'b1;
    bus.alloc_req       = 1'b1;
    bus.retire_en       = 1'b1;
    bus.retire_old_phys = 6'd9;
    #1;
    checks++;
    if (bus.alloc_valid !== 1'b0) begin
      errors++;
      $display("FAIL fr_valid: valid=%0b, want 0", bus.alloc_valid);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (bus.free_count !== 7'd32) begin
      errors++;
      $display("FAIL fr_count: count=%0d, want 32", bus.free_count);
    end
    wait_alloc_valid("fr");
    drain("fr_list", 32, 33, 1'b1, 9);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.alloc_req       = 1'b1;
      bus.retire_en       = 1'b1;
      bus.retire_old_phys = PRB'(10 + i);
      #1;
      checks++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_phys !== PRB'(32 + i) || bus.free_count !== 7'd32) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%0b phys=%0d count=%0d, want 1/%0d/32",
                 i, bus.alloc_valid, bus.alloc_phys, bus.free_count, 32 + i);
      end
      step();
    end
    idle_inputs();
    #1;
    checks++;
    if (bus.free_count !== 7'd32 || bus.alloc_phys !== 6'd35) begin
      errors++;
      $display("FAIL b2b_end: count=%0d phys=%0d, want 32/35", bus.free_count, bus.alloc_phys);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      bus.retire_en       = 1'b1;
      bus.retire_old_phys = PRB'(i + 1);
      step();
    end
    idle_inputs();
    #1;
    checks++;
    if (bus.free_count !== 7'd64) begin
      errors++;
      $display("FAIL full_count: count=%0d, want 64", bus.free_count);
    end
`ifndef FREELIST_CHECK_EN
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL full_err: err=%0b, want 0", bus.err);
    end
`endif
    bus.retire_en       = 1'b1;
    bus.retire_old_phys = 6'd20;
    step();
    idle_inputs();
    #1;
    checks++;
    if (bus.err !== 1'b1 || bus.free_count !== 7'd64) begin
      errors++;
      $display("FAIL overflow: err=%0b count=%0d, want 1/64", bus.err, bus.free_count);
    end
    step();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%0b, want 1", bus.err);
    end
    // Slot 32 must still hold the first retired value, 1.
    drain("ovf_skip", 32, 32, 1'b0, 0);
    checks++;
    if (bus.alloc_phys !== 6'd1) begin
      errors++;
      $display("FAIL ovf_dropped: phys=%0d, want 1", bus.alloc_phys);
    end
    do_reset();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%0b, want 0", bus.err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drain("mid_pre", 4, 32, 1'b0, 0);
    bus.alloc_req = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.free_count !== 7'd32 || bus.alloc_phys !== 6'd32) begin
      errors++;
      $display("FAIL reset_mid: count=%0d phys=%0d, want 32/32", bus.free_count, bus.alloc_phys);
    end
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
  endtask

  task automatic test_free_checks();
    do_reset();
`ifdef FREELIST_CHECK_EN
    bus.retire_en       = 1'b1;
    bus.retire_old_phys = 6'd40;
    step();
    idle_inputs();
    #1;
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL double_free: err=%0b, want 1", bus.err);
    end
    step();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL double_free_sticky: err=%0b, want 1", bus.err);
    end
    do_reset();
    bus.retire_en       = 1'b1;
    bus.retire_old_phys = 6'd0;
    step();
    idle_inputs();
    #1;
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL free_zero: err=%0b, want 1", bus.err);
    end
`else
    bus.retire_en       = 1'b1;
    bus.retire_old_phys = 6'd0;
    step();
    idle_inputs();
    #1;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL free_zero_nocheck: err=%0b, want 0", bus.err);
    end
`endif
  endtask

  // sequence and report
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alloc_all();
    test_retire_from_empty();
    test_flush();
    test_flush_retire();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_free_checks();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
